adv7513_video_timing: RTL and testbench
=======================================

// Module: adv7513_video_timing
// PURPOSE
//  Parallel-video source stage feeding the ADV7513 HDMI transmitter once the I2C init block reports done.
//  Generates DE/HSYNC/VSYNC raster timing on the pixel clock domain.
//  Pulls RGB pixels from the upstream frame source via a ready/valid handshake.
//  Drives the ADV7513 data bus, substituting black and flagging underflow when the source is late.
// PARAMETERS
//  H_ACTIVE  1280  active pixels per line
//  H_FP      110   horizontal front porch, pixels
//  H_SYNC    40    HSYNC width, pixels
//  H_BP      220   horizontal back porch, pixels
//  V_ACTIVE  720   active lines per frame
//  V_FP      5     vertical front porch, lines
//  V_SYNC    5     VSYNC width, lines
//  V_BP      20    vertical back porch, lines
//  HS_POL    1     HSYNC active level (1=active-high)
//  VS_POL    1     VSYNC active level (1=active-high)
//  PIX_W     24    pixel width (RGB 8:8:8)
// PORTS
//  clk          in   1      pixel clock; the single clock of the block
//  reset        in   1      asynchronous, active-low reset
//  enable       in   1      start/continue video; tie to init done; synchronous to clk
//  pix_data     in   PIX_W  upstream pixel
//  pix_valid    in   1      pix_data valid
//  pix_ready    out  1      block consumes pix_data this cycle
//  clr_underflow in  1      1-cycle pulse clears underflow
//  underflow    out  1      sticky: a pixel was needed with pix_valid=0
//  frame_start  out  1      1-cycle pulse aligned with first DE of each frame
//  hdmi_de      out  1      data enable to ADV7513
//  hdmi_hs      out  1      HSYNC to ADV7513
//  hdmi_vs      out  1      VSYNC to ADV7513
//  hdmi_d       out  PIX_W  pixel bus to ADV7513
// BEHAVIOUR
//  - Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  - Counters h_cnt and v_cnt are 12 bits, unsigned.
//  - Line order: active, front porch, sync, back porch. Frame order is the same, in lines.
//  - Reset values: hdmi_de=0, hdmi_hs=~HS_POL, hdmi_vs=~VS_POL, hdmi_d=0, pix_ready=0, frame_start=0, underflow=0, state=IDLE, counters=0.
//  - Reset asserted mid-frame forces all reset values immediately (async).
//  - FSM IDLE:
//     - Counters held at 0; outputs at reset levels.
//     - enable=1 -> RUN; the first RUN cycle has h=0, v=0.
//  - FSM RUN:
//     - h increments each cycle. At h=H_TOTAL-1 it wraps to 0 and v increments.
//     - At h=H_TOTAL-1 and v=V_TOTAL-1: if enable=1, both wrap to 0; else -> IDLE.
//     - Frames are never truncated. Deasserting enable mid-frame finishes the current frame.
//  - pix_ready is combinational: RUN && h<H_ACTIVE && v<V_ACTIVE.
//  - Outputs are registered from the current counters (1-cycle latency):
//     - hdmi_de(N+1) = pix_ready(N)
//     - hdmi_hs(N+1) = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; else ~HS_POL
//     - hdmi_vs(N+1) = VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines; else ~VS_POL
//  - hdmi_d(N+1):
//     - pix_data(N) when pix_ready && pix_valid
//     - 0 when pix_ready && !pix_valid; underflow<=1
//     - 0 outside active region
//  - Upstream handshake: transfer occurs on pix_ready && pix_valid. A late pixel is not replayed; the stream slips.
//  - frame_start(N+1) = RUN && h=0 && v=0 at cycle N.
//  - underflow is sticky until clr_underflow or reset. If set and clear occur in the same cycle, set wins.
// TESTING (small params: H 8/2/3/2 -> H_TOTAL=15; V 4/1/2/1 -> V_TOTAL=8; frame=120 cycles)
//  1. Reset, enable=1, pix_valid=1, pix_data=incrementing from 0
//     -> DE is high 8 cycles per line, on 4 lines; hdmi_d=0..31 in order.
//     -> hs is high at h=10..12 of every line.
//     -> vs is high on lines 5..6.
//  2. Counter wrap: observe two frames
//     -> frame_start pulses are exactly 120 cycles apart, each aligned with the first DE.
//     -> No DE on lines 4..7.
//  3. Drop pix_valid for 1 active cycle at h=3, v=1
//     -> hdmi_d=0 one cycle later with DE=1; underflow=1 and stays set.
//     -> clr_underflow pulse -> underflow=0.
//  4. Deassert enable at v=1 -> frame completes through h=14, v=7, then DE=0 and hs/vs idle.
//     Re-assert enable -> new frame from h=0, v=0 with frame_start.
//  5. Assert reset at h=5, v=2 -> same cycle: DE=0, pix_ready=0, hdmi_d=0, hs/vs at inactive levels.
//  6. HS_POL=0, VS_POL=0 -> hs/vs idle 1; low during the same sync windows as in test 1.

Source files
------------

// File: rtl/adv7513_video_timing.sv
// Raster timing generator and pixel bus driver for the ADV7513 HDMI transmitter.
// Pulls pixels over ready/valid and substitutes black (flagging underflow) when the source is late.
module adv7513_video_timing #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned PIX_W    = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             clr_underflow,
  output logic             underflow,
  output logic             frame_start,
  output logic             hdmi_de,
  output logic             hdmi_hs,
  output logic             hdmi_vs,
  output logic [PIX_W-1:0] hdmi_d
);

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             run_c;
  logic             hs_win_c;
  logic             vs_win_c;
  logic             origin_c;

  assign run_c     = (state == RUN);
  assign pix_ready = run_c && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs_win_c  = run_c && (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_win_c  = run_c && (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign origin_c  = run_c && (h_cnt == '0) && (v_cnt == '0);

  // Raster FSM; enable is only sampled at the last pixel so frames always complete
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (enable) state <= RUN;
        end
        RUN: begin
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
              v_cnt <= '0;
              if (!enable) state <= IDLE;
            end else begin
              v_cnt <= v_cnt + CNT_W'(1);
            end
          end else begin
            h_cnt <= h_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          h_cnt <= '0;
          v_cnt <= '0;
        end
      endcase
    end
  end

  // Output stage, one cycle behind the counters; late pixels become black
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdmi_de     <= 1'b0;
      hdmi_hs     <= ~HS_POL;
      hdmi_vs     <= ~VS_POL;
      hdmi_d      <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      hdmi_de     <= pix_ready;
      hdmi_hs     <= hs_win_c ? HS_POL : ~HS_POL;
      hdmi_vs     <= vs_win_c ? VS_POL : ~VS_POL;
      hdmi_d      <= (pix_ready && pix_valid) ? pix_data : '0;
      frame_start <= origin_c;
      if (pix_ready && !pix_valid) begin
        underflow <= 1'b1;
      end else if (clr_underflow) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adv7513_video_timing.sv
// Directed bench for adv7513_video_timing on a reduced 15x8 raster; a second
// instance with inverted sync polarity runs alongside on the same stimulus.
module tb_adv7513_video_timing;

  localparam int unsigned PW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [PW-1:0] pix_data;
  logic          pix_valid;
  logic          clr_underflow;

  logic          pix_ready, underflow, frame_start, hdmi_de, hdmi_hs, hdmi_vs;
  logic [PW-1:0] hdmi_d;
  logic          pix_ready_n, underflow_n, frame_start_n, hdmi_de_n, hdmi_hs_n, hdmi_vs_n;
  logic [PW-1:0] hdmi_d_n;

  int n_checks = 0;
  int n_errors = 0;
  int t        = 0;
  int exp_idx  = 0;
  bit exp_uf   = 1'b0;
  int last_fs  = -1;

  always #5 clk = ~clk;

  adv7513_video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_W(PW)
  ) u_dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .clr_underflow(clr_underflow), .underflow(underflow), .frame_start(frame_start),
    .hdmi_de(hdmi_de), .hdmi_hs(hdmi_hs), .hdmi_vs(hdmi_vs), .hdmi_d(hdmi_d)
  );

  adv7513_video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_W(PW)
  ) u_dut_neg (
    .clk(clk), .reset(reset), .enable(enable),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready_n),
    .clr_underflow(clr_underflow), .underflow(underflow_n), .frame_start(frame_start_n),
    .hdmi_de(hdmi_de_n), .hdmi_hs(hdmi_hs_n), .hdmi_vs(hdmi_vs_n), .hdmi_d(hdmi_d_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d: got %0d expected %0d", tag, t, got, exp);
    end
  endtask

  // Outputs registered from an IDLE cycle must all sit at reset levels
  task automatic idle_cycle();
    check("idle_ready", 32'(pix_ready), 32'd0);
    @(posedge clk); #1;
    check("idle_de", 32'(hdmi_de), 32'd0);
    check("idle_hs", 32'(hdmi_hs), 32'd0);
    check("idle_vs", 32'(hdmi_vs), 32'd0);
    check("idle_hs_n", 32'(hdmi_hs_n), 32'd1);
    check("idle_vs_n", 32'(hdmi_vs_n), 32'd1);
    check("idle_fs", 32'(frame_start), 32'd0);
    check("idle_d", 32'(hdmi_d), 32'd0);
  endtask

  // Runs n raster cycles; t counts cycles since the first RUN cycle (h=0,v=0)
  task automatic run_cycles(input int n, input int drop_t, input int clr_t, input int dis_t);
    int h, v, exp_d;
    bit rdy, vld, hs_on, vs_on;
    for (int k = 0; k < n; k++) begin
      h     = t % 15;
      v     = (t / 15) % 8;
      rdy   = (h < 8) && (v < 4);
      hs_on = (h >= 10) && (h <= 12);
      vs_on = (v >= 5) && (v <= 6);
      vld   = (t != drop_t);
      pix_valid     = vld;
      clr_underflow = (t == clr_t);
      if (t == dis_t) enable = 1'b0;
      pix_data = PW'(exp_idx);
      check("pix_ready", 32'(pix_ready), 32'(rdy));
      @(posedge clk); #1;
      exp_d = (rdy && vld) ? exp_idx : 0;
      if (rdy && vld) exp_idx++;
      if (rdy && !vld) exp_uf = 1'b1;
      else if (t == clr_t) exp_uf = 1'b0;
      check("de", 32'(hdmi_de), 32'(rdy));
      check("hs", 32'(hdmi_hs), 32'(hs_on));
      check("vs", 32'(hdmi_vs), 32'(vs_on));
      check("hs_n", 32'(hdmi_hs_n), 32'(!hs_on));
      check("vs_n", 32'(hdmi_vs_n), 32'(!vs_on));
      check("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
      check("hdmi_d", 32'(hdmi_d), 32'(exp_d));
      check("underflow", 32'(underflow), 32'(exp_uf));
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) check("fs_gap", 32'(t - last_fs), 32'd120);
        last_fs = t;
      end
      pix_valid     = 1'b1;
      clr_underflow = 1'b0;
      t++;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; pix_valid = 1'b1; clr_underflow = 1'b0; pix_data = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_de", 32'(hdmi_de), 32'd0);
    check("rst_hs", 32'(hdmi_hs), 32'd0);
    check("rst_vs", 32'(hdmi_vs), 32'd0);
    check("rst_hs_n", 32'(hdmi_hs_n), 32'd1);
    check("rst_vs_n", 32'(hdmi_vs_n), 32'd1);
    check("rst_d", 32'(hdmi_d), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_uf", 32'(underflow), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle_cycle();
    idle_cycle();

    // Two clean frames with continuous valid data
    enable = 1'b1;
    idle_cycle();
    t = 0;
    run_cycles(240, -1, -1, -1);

    // One late pixel at h=3,v=1, then clear the sticky flag in the porch
    run_cycles(120, 258, 265, -1);

    // Drop enable on line 1; frame must still complete before going idle
    run_cycles(120, -1, -1, 375);
    repeat (3) idle_cycle();
    enable = 1'b1;
    idle_cycle();
    t = 0;
    last_fs = -1;
    // Drop and clear in the same cycle: the set must win
    run_cycles(35, 20, 20, -1);

    // Async reset mid-frame at h=5,v=2
    check("pre_rst_ready", 32'(pix_ready), 32'd1);
    check("pre_rst_de", 32'(hdmi_de), 32'd1);
    reset = 1'b0;
    #1;
    check("arst_de", 32'(hdmi_de), 32'd0);
    check("arst_ready", 32'(pix_ready), 32'd0);
    check("arst_d", 32'(hdmi_d), 32'd0);
    check("arst_hs", 32'(hdmi_hs), 32'd0);
    check("arst_vs", 32'(hdmi_vs), 32'd0);
    check("arst_hs_n", 32'(hdmi_hs_n), 32'd1);
    check("arst_vs_n", 32'(hdmi_vs_n), 32'd1);
    check("arst_uf", 32'(underflow), 32'd0);
    check("arst_fs", 32'(frame_start), 32'd0);
    #20 reset = 1'b1;
    #20;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
